// File: rtl/count_expander.sv
// Count expander: turns a binary count N into a thermometer word holding
// exactly min(N, WIDTH) ones, and streams that word out LSB-first with a handshake.
module count_expander #(
  parameter int WIDTH = 15,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_count,
  output logic [WIDTH-1:0] therm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic             busy,
  output logic             sat_err,
  input  logic             sat_clr
);

  localparam int             IW       = $clog2(WIDTH);
  localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW:0]    WIDTH_C  = (CW + 1)'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] therm_q, therm_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             sat_q, sat_d;

  logic accept;
  logic sat_hit;

  // Bits at or above WIDTH never exist, so counts beyond WIDTH clamp naturally.
  function automatic logic [WIDTH-1:0] thermo(input logic [CW-1:0] n);
    logic [WIDTH-1:0] t;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

  assign out_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign out_bit   = shreg_q[0];
  assign out_last  = (state_q == SHIFT) && (idx_q == LAST_IDX);
  // out_ready -> in_ready is the only combinational path through the block.
  assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
  assign therm     = therm_q;
  assign sat_err   = sat_q;

  assign accept  = in_valid && in_ready;
  assign sat_hit = ({1'b0, in_count} > WIDTH_C);

  always_comb begin
    state_d = state_q;
    therm_d = therm_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    sat_d   = sat_q;

    if (sat_clr) sat_d = 1'b0;
    if (accept && sat_hit) sat_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          therm_d = thermo(in_count);
          shreg_d = thermo(in_count);
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            // Last beat: reload without a bubble if a new count is waiting.
            if (in_valid) begin
              therm_d = thermo(in_count);
              shreg_d = thermo(in_count);
              idx_d   = '0;
            end else begin
              shreg_d = '0;
              idx_d   = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      therm_q <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      therm_q <= therm_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
    end
  end

endmodule
